// File: rtl/fifo_rr_scheduler_if.sv
// fifo_rr_scheduler_if: control/data bundle between the scheduler and its input/output FIFO bank
interface fifo_rr_scheduler_if #(
  parameter int DATA_W = 6,
  parameter int CFG_W = 5
);
  logic init;
  logic [CFG_W-1:0] umbral_full;
  logic [CFG_W-1:0] umbral_empty;
  logic [3:0] fifo_empty_in;
  logic [3:0] valid_in;
  logic [4*DATA_W-1:0] data_in;
  logic [3:0] pause_in;
  logic [3:0] fifo_rd;
  logic [3:0] fifo_wr;
  logic [DATA_W-1:0] data_out;
  logic [CFG_W-1:0] al_full_cfg;
  logic [CFG_W-1:0] al_empty_cfg;
  logic [1:0] state;
  logic idle;
  logic err;
  modport master (
    output init, umbral_full, umbral_empty, fifo_empty_in, valid_in, data_in, pause_in,
    input fifo_rd, fifo_wr, data_out, al_full_cfg, al_empty_cfg, state, idle, err
  );
  modport slave (
    input init, umbral_full, umbral_empty, fifo_empty_in, valid_in, data_in, pause_in,
    output fifo_rd, fifo_wr, data_out, al_full_cfg, al_empty_cfg, state, idle, err
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin pop of four input FIFOs, each word routed by its top bits to an output FIFO
module fifo_rr_scheduler #(
  parameter int DATA_W = 6,
  parameter int DEST_W = 2,
  parameter int CFG_W = 5,
  parameter int CFG_FULL_DEF = 6,
  parameter int CFG_EMPTY_DEF = 1
) (
  input logic clk,
  input logic RESET,
  fifo_rr_scheduler_if.slave bus
);
  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  logic [1:0] state, state_nx, last, g, gnt_id;
  logic gnt_v, found, grant, push;
  logic [DATA_W-1:0] word;
  always_comb begin
    g = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++)
      if (!found && !bus.fifo_empty_in[last + 2'(k)]) begin
        g = last + 2'(k);
        found = 1'b1;
      end
  end
  assign grant = state != INIT && !bus.init && bus.pause_in == 4'b0 && found;
  assign bus.fifo_rd = grant ? 4'(1) << g : 4'b0;
  assign word = bus.data_in[DATA_W*gnt_id +: DATA_W];
  assign push = gnt_v && bus.valid_in[gnt_id];
  // leaving for INIT waits until the last granted word has been read back
  always_comb
    state_nx = state == INIT ? (bus.init ? INIT : IDLE)
             : bus.init ? (gnt_v ? state : INIT)
             : grant ? ACTIVE
             : gnt_v ? state : IDLE;
  assign bus.state = state;
  assign bus.idle = state == IDLE;
  always_ff @(posedge clk)
    if (RESET) begin
      state <= INIT;
      last <= 2'd3;
      gnt_v <= 1'b0;
      gnt_id <= 2'd0;
      bus.fifo_wr <= 4'b0;
      bus.data_out <= '0;
      bus.err <= 1'b0;
      bus.al_full_cfg <= CFG_W'(CFG_FULL_DEF);
      bus.al_empty_cfg <= CFG_W'(CFG_EMPTY_DEF);
    end else begin
      state <= state_nx;
      gnt_v <= grant;
      if (grant) begin
        last <= g;
        gnt_id <= g;
      end
      bus.fifo_wr <= push ? 4'(1) << word[DATA_W-1 -: DEST_W] : 4'b0;
      if (push) bus.data_out <= word;
      bus.err <= bus.err | (gnt_v && !bus.valid_in[gnt_id]) | |(bus.fifo_rd & bus.fifo_empty_in);
      if (state == INIT && bus.init) begin
        bus.al_full_cfg <= bus.umbral_full;
        bus.al_empty_cfg <= bus.umbral_empty;
      end
    end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed checks of grant order, routing, latency, pause, errors and reset
module tb_fifo_rr_scheduler;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic drop = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] mem [4][16];
  int wr_cnt [4] = '{default: 0};
  int rd_cnt [4] = '{default: 0};
  fifo_rr_scheduler_if #(.DATA_W(6), .CFG_W(5)) bus ();
  fifo_rr_scheduler dut (.clk(clk), .RESET(RESET), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.fifo_empty_in = 4'hF;
    for (int i = 0; i < 4; i++) bus.fifo_empty_in[i] = wr_cnt[i] == rd_cnt[i];
  end
  // input FIFO bank: registered read, valid one cycle after the pop unless withheld
  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      bus.valid_in[i] <= bus.fifo_rd[i] && !drop;
      if (bus.fifo_rd[i]) begin
        bus.data_in[6*i +: 6] <= mem[i][rd_cnt[i] % 16];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int i, input int w);
    mem[i][wr_cnt[i] % 16] = 6'(w);
    wr_cnt[i]++;
  endtask
  task automatic tick(input string tag, input int pz, input int rd, input int wr, input int d);
    bus.pause_in = 4'(pz);
    #1;
    chk({tag, " fifo_rd"}, 32'(bus.fifo_rd), rd);
    chk({tag, " fifo_wr"}, 32'(bus.fifo_wr), wr);
    if (wr != 0) chk({tag, " data_out"}, 32'(bus.data_out), d);
    @(negedge clk);
  endtask
  initial begin
    bus.init = 1'b0;
    bus.umbral_full = 5'd0;
    bus.umbral_empty = 5'd0;
    bus.pause_in = 4'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst state", 32'(bus.state), 0);
    chk("rst fifo_wr", 32'(bus.fifo_wr), 0);
    chk("rst data_out", 32'(bus.data_out), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst idle", 32'(bus.idle), 0);
    chk("rst al_full", 32'(bus.al_full_cfg), 6);
    chk("rst al_empty", 32'(bus.al_empty_cfg), 1);
    RESET = 1'b0;
    bus.init = 1'b1;
    bus.umbral_full = 5'd5;
    bus.umbral_empty = 5'd2;
    @(negedge clk);
    chk("init state", 32'(bus.state), 0);
    chk("init al_full", 32'(bus.al_full_cfg), 5);
    chk("init al_empty", 32'(bus.al_empty_cfg), 2);
    bus.init = 1'b0;
    @(negedge clk);
    chk("init->idle state", 32'(bus.state), 1);
    chk("init->idle idle", 32'(bus.idle), 1);
    chk("init->idle al_full", 32'(bus.al_full_cfg), 5);
    load(0, 'h05); load(0, 'h3F); load(1, 'h12); load(2, 'h2A); load(3, 'h33);
    tick("rr0", 0, 1, 0, 0);
    chk("rr active", 32'(bus.state), 2);
    tick("rr1", 0, 2, 0, 0);
    tick("rr2", 0, 4, 1, 'h05);
    tick("rr3", 0, 8, 2, 'h12);
    tick("rr4", 0, 1, 4, 'h2A);
    tick("rr5", 0, 0, 8, 'h33);
    tick("rr6", 0, 0, 8, 'h3F);
    chk("rr end fifo_wr", 32'(bus.fifo_wr), 0);
    chk("rr end state", 32'(bus.state), 1);
    chk("rr end err", 32'(bus.err), 0);
    load(2, 'h35); load(2, 'h0A);
    tick("rt0", 0, 4, 0, 0);
    tick("rt1", 0, 4, 0, 0);
    tick("rt2", 0, 0, 8, 'h35);
    tick("rt3", 0, 0, 1, 'h0A);
    chk("rt end fifo_wr", 32'(bus.fifo_wr), 0);
    chk("rt end state", 32'(bus.state), 1);
    load(3, 'h1C);
    tick("eb0", 0, 8, 0, 0);
    chk("eb active", 32'(bus.state), 2);
    tick("eb1", 0, 0, 0, 0);
    tick("eb2", 0, 0, 2, 'h1C);
    chk("eb idle state", 32'(bus.state), 1);
    chk("eb fifo_wr", 32'(bus.fifo_wr), 0);
    chk("eb err", 32'(bus.err), 0);
    load(0, 'h01); load(0, 'h21); load(0, 'h31);
    load(1, 'h11); load(1, 'h08); load(1, 'h28);
    tick("pz0", 0, 1, 0, 0);
    tick("pz1", 0, 2, 0, 0);
    tick("pz2", 2, 0, 1, 'h01);
    tick("pz3", 2, 0, 2, 'h11);
    tick("pz4", 2, 0, 0, 0);
    tick("pz5", 0, 1, 0, 0);
    tick("pz6", 0, 2, 0, 0);
    tick("pz7", 0, 1, 4, 'h21);
    tick("pz8", 0, 2, 1, 'h08);
    tick("pz9", 0, 0, 8, 'h31);
    tick("pz10", 0, 0, 4, 'h28);
    chk("pz end fifo_wr", 32'(bus.fifo_wr), 0);
    chk("pz end state", 32'(bus.state), 1);
    load(1, 'h15);
    drop = 1'b1;
    tick("er0", 0, 2, 0, 0);
    tick("er1", 0, 0, 0, 0);
    chk("er set", 32'(bus.err), 1);
    chk("er no push", 32'(bus.fifo_wr), 0);
    chk("er data held", 32'(bus.data_out), 'h28);
    drop = 1'b0;
    @(negedge clk);
    chk("er sticky", 32'(bus.err), 1);
    chk("er still no push", 32'(bus.fifo_wr), 0);
    load(0, 'h3A); load(0, 'h3B); load(0, 'h3C);
    tick("rs0", 0, 1, 0, 0);
    tick("rs1", 0, 1, 0, 0);
    chk("rs inflight push", 32'(bus.fifo_wr), 8);
    RESET = 1'b1;
    @(negedge clk);
    chk("rs fifo_wr", 32'(bus.fifo_wr), 0);
    chk("rs state", 32'(bus.state), 0);
    chk("rs err", 32'(bus.err), 0);
    chk("rs idle", 32'(bus.idle), 0);
    chk("rs data_out", 32'(bus.data_out), 0);
    chk("rs al_full", 32'(bus.al_full_cfg), 6);
    chk("rs al_empty", 32'(bus.al_empty_cfg), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Controller for a bank of four 6-bit input FIFOs (8-deep, 1-cycle registered read, valid_out) feeding four output FIFOs.
- Pops the input FIFOs round-robin and routes each word to an output FIFO chosen by the word's top 2 bits.
- Throttles all reads while any output FIFO asserts pause.
- Holds the almost-full and almost-empty threshold configuration that is broadcast to every FIFO, loaded through an INIT state.

Parameters:
DATA_W, 6, FIFO word width
DEST_W, 2, destination field width; destination = data[DATA_W-1 -: DEST_W]
CFG_W, 5, threshold width (matches al_full_in/al_empty_in)
CFG_FULL_DEF, 6, reset value of almost-full threshold
CFG_EMPTY_DEF, 1, reset value of almost-empty threshold

Ports:
clk  in  1  clock, all logic on posedge
RESET  in  1  synchronous, active-high reset
init  in  1  1 = enter/stay in INIT and load thresholds
umbral_full  in  CFG_W  almost-full threshold to load in INIT
umbral_empty  in  CFG_W  almost-empty threshold to load in INIT
fifo_empty_in  in  4  empty flag of input FIFO i (bit i)
valid_in  in  4  valid_out of input FIFO i
data_in  in  4*DATA_W  read data of input FIFO i at [DATA_W*i +: DATA_W]
pause_in  in  4  pause flag of output FIFO j
fifo_rd  out  4  one-hot pop to input FIFO i (combinational)
fifo_wr  out  4  one-hot push to output FIFO j (registered)
data_out  out  DATA_W  word to output FIFOs, valid with fifo_wr (registered)
al_full_cfg  out  CFG_W  almost-full threshold to all FIFOs (registered)
al_empty_cfg  out  CFG_W  almost-empty threshold to all FIFOs (registered)
state  out  2  0=INIT, 1=IDLE, 2=ACTIVE
idle  out  1  1 when state==IDLE
err  out  1  sticky protocol error

Behaviour:
- Reset values:
  - state=INIT.
  - fifo_wr=0, data_out=0, err=0, idle=0.
  - al_full_cfg=CFG_FULL_DEF, al_empty_cfg=CFG_EMPTY_DEF.
  - RR pointer last=3, so input 0 has first priority.
  - Pipeline registers cleared. In-flight words are discarded on RESET mid-traffic.
- INIT:
  - Every cycle with init=1, latch umbral_full into al_full_cfg and umbral_empty into al_empty_cfg.
  - No grants.
  - init=0 -> IDLE next cycle.
- Grant (combinational, evaluated only in IDLE/ACTIVE):
  - go = (pause_in==0) && !init.
  - Candidates are bits with fifo_empty_in[i]==0.
  - Search order: last+1, last+2, ... mod 4. The first candidate found is g.
  - fifo_rd = go ? onehot(g) : 0. At most one bit is set.
  - On a grant: last<=g, gnt_v<=1, gnt_id<=g. Otherwise gnt_v<=0.
- Read pipeline. Grant in cycle N:
  - Cycle N+1: input FIFO g presents valid_in[g] and data_in[g].
  - At the N+1 edge: if gnt_v, then data_out<=data_in[gnt_id] and fifo_wr<=onehot(dest of that word).
  - fifo_wr and data_out are visible in cycle N+2. Latency from fifo_rd to fifo_wr is exactly 2 cycles.
  - fifo_wr is 0 in any cycle not produced by a grant.
- Back-to-back operation:
  - A new grant is allowed every cycle, including to the same FIFO.
  - Throughput is 1 word/cycle.
  - Word order per input FIFO is preserved.
- err:
  - Set when gnt_v=1 and valid_in[gnt_id]=0.
  - Set when a fifo_rd bit is found asserted with its fifo_empty_in bit high; this is checked defensively.
  - Cleared only by RESET.
  - On a missing valid, no push is generated for that slot.
- pause handling:
  - Any pause_in bit blocks new grants in that same cycle.
  - Up to 2 words already in flight still push, so al_full_cfg must leave at least 2 entries of headroom (default 6 of 8 does).
  - Pushes are never suppressed.
- State transitions:
  - IDLE -> ACTIVE on the cycle a grant is issued.
  - ACTIVE -> IDLE when no grant is issued, gnt_v=0, and no push is pending.
  - IDLE/ACTIVE -> INIT when init=1: grants stop immediately and the state moves to INIT once the pipeline is empty. The cfg outputs do not change until then.
- Thresholds change only in INIT and never while traffic is in flight.

Test Plan:
- Reset then INIT: hold init=1 with umbral_full=5, umbral_empty=2, then drop init -> al_full_cfg=5, al_empty_cfg=2, state=IDLE next cycle. After RESET the values are 6 and 1.
- Round robin: all 4 inputs non-empty, no pause -> fifo_rd sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Routing and latency: input 2 holds words 6'b11_0101 and 6'b00_1010 -> fifo_rd[2] at cycles N and N+1. At N+2, fifo_wr=1000 with data_out=6'h35; at N+3, fifo_wr=0001 with data_out=6'h0A.
- Pause: set pause_in[1]=1 while streaming -> fifo_rd=0 in that same cycle, at most 2 more fifo_wr pulses follow, and traffic resumes from the next RR candidate after pause clears.
- Empty boundary: only input 3 non-empty with 1 word -> single fifo_rd=1000, one fifo_wr, state back to IDLE 3 cycles after the grant, err=0.
- Errors and reset mid-flight: withhold valid_in after a grant -> err=1 (sticky) and no push. Assert RESET while words are in flight -> fifo_wr=0 next cycle, state=INIT, err=0.
